// File: rtl/key_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : key_conditioner
// Brief    : Per-key synchronizer, debouncer, press/release edge pulses and
//            auto-repeat pulse generator for raw push-button pins.
// Revision : 1.0  initial release
// ============================================================================
module key_conditioner #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int KEY_ACTIVE_LOW  = 1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] keys,
    output logic [NUM_KEYS-1:0] keys_press,
    output logic [NUM_KEYS-1:0] keys_release,
    output logic [NUM_KEYS-1:0] keys_repeat
);

    localparam int c_DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_RPT_W   = $clog2(c_RPT_MAX + 1);

    // Level of an idle (unpressed) pin; the synchronizer resets to it.
    localparam logic c_RELEASED = (KEY_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    localparam logic [c_DB_W-1:0]  c_DB_TERM    = c_DB_W'(DEBOUNCE_CYCLES);
    localparam logic [c_RPT_W-1:0] c_RPT_DELAY  = c_RPT_W'(REPEAT_DELAY);
    localparam logic [c_RPT_W-1:0] c_RPT_PERIOD = c_RPT_W'(REPEAT_PERIOD);
    localparam logic [c_RPT_W-1:0] c_RPT_SAT    = c_RPT_W'(c_RPT_MAX);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_DELAY  = 2'd1;
    localparam logic [1:0] c_ST_REPEAT = 2'd2;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        logic               r_sync1;
        logic               r_sync2;
        logic               r_sample;
        logic [c_DB_W-1:0]  r_db_cnt;
        logic               r_level;
        logic               r_press;
        logic               r_release;
        logic [1:0]         r_state;
        logic [c_RPT_W-1:0] r_rpt_cnt;
        logic               r_repeat;

        logic               w_differs;
        logic [c_DB_W-1:0]  w_db_inc;
        logic               w_toggle;
        logic               w_level_next;
        logic               w_accept_press;
        logic               w_accept_release;
        logic [c_RPT_W-1:0] w_rpt_inc;
        logic [1:0]         w_state_next;
        logic [c_RPT_W-1:0] w_rpt_cnt_next;
        logic               w_rpt_pulse;

        assign w_differs        = (r_sample != r_level);
        assign w_db_inc         = r_db_cnt + c_DB_W'(1);
        assign w_toggle         = w_differs && (w_db_inc == c_DB_TERM);
        assign w_level_next     = r_level ^ w_toggle;
        assign w_accept_press   = w_toggle && !r_level;
        assign w_accept_release = w_toggle && r_level;

        // Synchronizer, normalization stage and debounce counter.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_sync1   <= c_RELEASED;
                r_sync2   <= c_RELEASED;
                r_sample  <= 1'b0;
                r_db_cnt  <= '0;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_sync1   <= key_raw[i];
                r_sync2   <= r_sync1;
                r_sample  <= r_sync2 ^ c_RELEASED;
                r_level   <= w_level_next;
                r_press   <= w_accept_press;
                r_release <= w_accept_release;
                if (!w_differs || w_toggle) begin
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= w_db_inc;
                end
            end
        end

        assign w_rpt_inc = (r_rpt_cnt == c_RPT_SAT) ? r_rpt_cnt : (r_rpt_cnt + c_RPT_W'(1));

        // The release decision looks at the level being written this edge so
        // that no repeat pulse can coincide with the release pulse.
        always_comb begin
            w_state_next   = r_state;
            w_rpt_cnt_next = r_rpt_cnt;
            w_rpt_pulse    = 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    w_rpt_cnt_next = '0;
                    if (w_accept_press) begin
                        w_state_next = c_ST_DELAY;
                        w_rpt_pulse  = 1'b1;
                    end
                end
                c_ST_DELAY: begin
                    if (!w_level_next) begin
                        w_state_next   = c_ST_IDLE;
                        w_rpt_cnt_next = '0;
                    end else if (w_rpt_inc == c_RPT_DELAY) begin
                        w_state_next   = c_ST_REPEAT;
                        w_rpt_cnt_next = '0;
                        w_rpt_pulse    = 1'b1;
                    end else begin
                        w_rpt_cnt_next = w_rpt_inc;
                    end
                end
                c_ST_REPEAT: begin
                    if (!w_level_next) begin
                        w_state_next   = c_ST_IDLE;
                        w_rpt_cnt_next = '0;
                    end else if (w_rpt_inc == c_RPT_PERIOD) begin
                        w_rpt_cnt_next = '0;
                        w_rpt_pulse    = 1'b1;
                    end else begin
                        w_rpt_cnt_next = w_rpt_inc;
                    end
                end
                default: begin
                    w_state_next   = c_ST_IDLE;
                    w_rpt_cnt_next = '0;
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_state   <= c_ST_IDLE;
                r_rpt_cnt <= '0;
                r_repeat  <= 1'b0;
            end else begin
                r_state   <= w_state_next;
                r_rpt_cnt <= w_rpt_cnt_next;
                r_repeat  <= w_rpt_pulse;
            end
        end

        assign keys[i]         = r_level;
        assign keys_press[i]   = r_press;
        assign keys_release[i] = r_release;
        assign keys_repeat[i]  = r_repeat;
    end

endmodule
`default_nettype wire

// File: tb/tb_key_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_conditioner
// Brief    : Directed and randomized bench for key_conditioner against a
//            cycle-level reference model built from the timing rules.
// Revision : 1.0  initial release
// ============================================================================
module tb_key_conditioner;

    localparam int NK = 4;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;
    localparam int AL = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [NK-1:0] key_raw;
    logic [NK-1:0] keys;
    logic [NK-1:0] keys_press;
    logic [NK-1:0] keys_release;
    logic [NK-1:0] keys_repeat;

    key_conditioner #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (DB),
        .KEY_ACTIVE_LOW  (AL),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .key_raw      (key_raw),
        .keys         (keys),
        .keys_press   (keys_press),
        .keys_release (keys_release),
        .keys_repeat  (keys_repeat)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: 3-edge input pipeline, accepted level, run length of
    // disagreeing samples, and cycles elapsed since the accepted press.
    int            pipe [NK][3];
    int            lvl  [NK];
    int            run  [NK];
    int            age  [NK];
    logic [NK-1:0] m_keys, m_press, m_rel, m_rep;

    task automatic model_step();
        int sample;
        for (int k = 0; k < NK; k++) begin
            m_press[k] = 1'b0;
            m_rel[k]   = 1'b0;
            m_rep[k]   = 1'b0;
            if (reset) begin
                for (int s = 0; s < 3; s++) pipe[k][s] = 0;
                lvl[k] = 0;
                run[k] = 0;
                age[k] = 0;
            end else begin
                sample     = pipe[k][2];
                pipe[k][2] = pipe[k][1];
                pipe[k][1] = pipe[k][0];
                pipe[k][0] = (key_raw[k] == ((AL != 0) ? 1'b0 : 1'b1)) ? 1 : 0;
                if (sample != lvl[k]) begin
                    run[k]++;
                    if (run[k] == DB) begin
                        lvl[k] = sample;
                        run[k] = 0;
                        if (lvl[k] == 1) m_press[k] = 1'b1;
                        else             m_rel[k]   = 1'b1;
                    end
                end else begin
                    run[k] = 0;
                end
                if (lvl[k] == 1) begin
                    age[k]   = m_press[k] ? 0 : age[k] + 1;
                    m_rep[k] = (age[k] == 0) || (age[k] >= RD && ((age[k] - RD) % RP) == 0);
                end
            end
            m_keys[k] = (lvl[k] == 1);
        end
    endtask

    task automatic check(input string tag, input logic [NK-1:0] obs, input logic [NK-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s at t=%0t observed=%b expected=%b", tag, $time, obs, exp);
    endtask

    task automatic cycle(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            model_step();
            #1;
            check("keys",         keys,         m_keys);
            check("keys_press",   keys_press,   m_press);
            check("keys_release", keys_release, m_rel);
            check("keys_repeat",  keys_repeat,  m_rep);
        end
    endtask

    initial begin
        reset   = 1'b1;
        key_raw = 4'hF;
        cycle(3);
        reset = 1'b0;
        cycle(5);

        // Short glitch on key 0 must never be accepted.
        key_raw[0] = 1'b0;
        cycle(3);
        key_raw[0] = 1'b1;
        cycle(10);

        // Clean press with long hold, then release.
        key_raw[0] = 1'b0;
        cycle(40);
        key_raw[0] = 1'b1;
        cycle(12);

        // Simultaneous press on keys 1 and 3.
        key_raw = 4'b0101;
        cycle(30);
        key_raw = 4'hF;
        cycle(12);

        // Key 2 reaches auto-repeat, then a one-cycle reset while held.
        key_raw = 4'b1011;
        cycle(22);
        reset = 1'b1;
        cycle(1);
        reset = 1'b0;
        cycle(25);
        key_raw = 4'hF;
        cycle(12);

        // Randomized activity with occasional short glitches and resets.
        for (int t = 0; t < 2000; t++) begin
            for (int k = 0; k < NK; k++) begin
                if ($urandom_range(0, 15) == 0) key_raw[k] = ~key_raw[k];
            end
            reset = ($urandom_range(0, 499) == 0);
            cycle(1);
        end
        reset = 1'b0;
        key_raw = 4'hF;
        cycle(20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 Parameter: NUM_KEYS, default 4, number of independent key channels.
REQ-002 Parameter: DEBOUNCE_CYCLES, default 500000, clock cycles a synchronized level must stay stable before acceptance (10 ms at 50 MHz); legal range >= 1.
REQ-003 Parameter: KEY_ACTIVE_LOW, default 1, 1 = raw pin reads 0 when pressed.
REQ-004 Parameter: REPEAT_DELAY, default 25000000, cycles from accepted press to first auto-repeat pulse; legal range >= 1.
REQ-005 Parameter: REPEAT_PERIOD, default 5000000, cycles between subsequent auto-repeat pulses; legal range >= 1.
REQ-006 Port: clk  input  1  single system clock, all logic on its rising edge.
REQ-007 Port: reset  input  1  synchronous, active-high reset.
REQ-008 Port: key_raw  input  NUM_KEYS  asynchronous raw button pins.
REQ-009 Port: keys  output  NUM_KEYS  debounced level, 1 = pressed, independent of KEY_ACTIVE_LOW; drives the game wrapper keys input.
REQ-010 Port: keys_press  output  NUM_KEYS  one-cycle pulse per accepted press.
REQ-011 Port: keys_release  output  NUM_KEYS  one-cycle pulse per accepted release.
REQ-012 Port: keys_repeat  output  NUM_KEYS  one-cycle pulse on press and at each auto-repeat instant while held.

Function
REQ-013 Each key channel shall be fully independent; simultaneous activity on several keys shall not interact.
REQ-014 Each raw bit shall pass a 2-flop synchronizer, then be normalized to pressed=1 via KEY_ACTIVE_LOW; no other logic shall sample key_raw directly.
REQ-015 Per key: a debounce counter, width clog2(DEBOUNCE_CYCLES+1), shall clear whenever the normalized sample equals keys[i].
REQ-016 While the sample differs from keys[i], the counter shall increment each cycle; when it would reach DEBOUNCE_CYCLES, keys[i] shall toggle and the counter shall clear in the same edge.
REQ-017 A raw level held steady shall appear on keys[i] exactly 2 + DEBOUNCE_CYCLES edges after the first edge that samples it; any reversion before then shall discard the change with no output activity.
REQ-018 keys_press[i] shall be 1 exactly in the cycle keys[i] first reads 1; keys_release[i] exactly in the cycle keys[i] first reads 0; never both in the same cycle.
REQ-019 Repeat FSM per key, states IDLE, DELAY, REPEAT; IDLE->DELAY on accepted press (keys_repeat pulses that cycle, counter cleared).
REQ-020 DELAY: count to REPEAT_DELAY, then pulse keys_repeat, clear counter, go REPEAT; REPEAT: pulse every REPEAT_PERIOD cycles.
REQ-021 From DELAY or REPEAT, keys[i]=0 shall force IDLE in the same edge, clear the counter, suppress any pulse due that cycle.
REQ-022 Repeat counter width shall be clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1); counters shall never wrap, saturating at their terminal value.
REQ-023 All outputs shall be registered; no combinational path from key_raw to any output.

Reset
REQ-024 While reset=1 at a rising edge: keys, keys_press, keys_release, keys_repeat = 0; all counters 0; FSMs IDLE; synchronizer flops loaded with the released raw level (1 when KEY_ACTIVE_LOW=1).
REQ-025 Reset asserted mid-debounce or mid-repeat shall abort without any pulse; after release a still-held key shall be re-accepted via the full REQ-017 latency and produce a fresh keys_press.

Verification (NUM_KEYS=4, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, KEY_ACTIVE_LOW=1)
REQ-026 Glitch: key_raw[0]=0 for 3 cycles then 1 -> keys=0000, no press/release/repeat pulses at any time.
REQ-027 Clean press at edge T held -> keys[0]=1 from T+6, keys_press[0] and keys_repeat[0] single pulses at T+6.
REQ-028 Hold 40 cycles from REQ-027 -> keys_repeat[0] pulses at T+6, T+16, T+19, T+22, ... exactly, no others.
REQ-029 Release after hold at edge R -> keys[0]=0 and keys_release[0] pulse at R+6, repeat pulses cease immediately.
REQ-030 key_raw[1] and key_raw[3] pressed on the same edge -> identical timing on bits 1 and 3, bits 0 and 2 stay 0.
REQ-031 Reset pulsed for 1 cycle while key 2 is in REPEAT -> all outputs 0 next cycle; key still held -> keys_press[2] 6 cycles after reset deasserts.
